// File: rtl/arch_regfile_commit.sv
// Architectural register file and rename status at the ROB commit bus; 4 combinational read ports.
// Commit/flush take effect the cycle after the trigger; COMMIT_BYPASS_EN forwards a committing value in the trigger cycle.
module arch_regfile_commit #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 3,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_alloc_valid,
  input  logic [TAG_W-1:0]  i_alloc_tag,
  input  logic              i_alloc_we_a,
  input  logic              i_alloc_we_b,
  input  logic [REG_W-1:0]  i_alloc_rd_a,
  input  logic [REG_W-1:0]  i_alloc_rd_b,
  input  logic              i_rob_bus_trigger,
  input  logic              i_rob_exception_flush,
  input  logic [TAG_W-1:0]  i_rob_bus_tag,
  input  logic [DATA_W-1:0] i_rob_bus_value,
  input  logic [REG_W-1:0]  i_rd_sel   [4],
  output logic [DATA_W-1:0] o_rd_value [4],
  output logic              o_rd_ready [4],
  output logic [TAG_W-1:0]  o_rd_tag   [4],
  output logic [15:0]       o_commit_count,
  output logic              o_stale_commit
);

  localparam int NREG = 1 << REG_W;
  localparam int NTAG = 1 << TAG_W;

  logic [DATA_W-1:0] r_regs   [NREG];
  logic [NREG-1:0]   r_busy;
  logic [TAG_W-1:0]  r_tag    [NREG];
  logic [NTAG-1:0]   r_ent_vld;
  logic [NTAG-1:0]   r_ent_we;
  logic [REG_W-1:0]  r_ent_rd [NTAG];
  logic [15:0]       r_commit_count;
  logic              r_stale;

  logic              w_commit;
  logic              w_flush;
  logic              w_e_vld;
  logic              w_e_we;
  logic [REG_W-1:0]  w_e_rd;
  logic [TAG_W-1:0]  w_tag_b;

  assign w_commit = i_rob_bus_trigger & ~i_rob_exception_flush;
  assign w_flush  = i_rob_bus_trigger &  i_rob_exception_flush;
  assign w_e_vld  = r_ent_vld[i_rob_bus_tag];
  assign w_e_we   = r_ent_we[i_rob_bus_tag];
  assign w_e_rd   = r_ent_rd[i_rob_bus_tag];
  assign w_tag_b  = i_alloc_tag + TAG_W'(1);

  // Later nonblocking writes win: alloc after commit, slot b after slot a.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_tag[i]  <= '0;
      end
      for (int t = 0; t < NTAG; t++) r_ent_rd[t] <= '0;
      r_busy         <= '0;
      r_ent_vld      <= '0;
      r_ent_we       <= '0;
      r_commit_count <= '0;
      r_stale        <= 1'b0;
    end else begin
      r_stale <= 1'b0;
      if (w_flush) begin
        r_busy    <= '0;
        r_ent_vld <= '0;
      end else begin
        if (w_commit) begin
          r_ent_vld[i_rob_bus_tag] <= 1'b0;
          if (!w_e_vld) begin
            r_stale <= 1'b1;
          end else if (w_e_we) begin
            r_regs[w_e_rd] <= i_rob_bus_value;
            r_commit_count <= r_commit_count + 16'd1;
            if (r_tag[w_e_rd] == i_rob_bus_tag) r_busy[w_e_rd] <= 1'b0;
          end
        end
        if (i_alloc_valid) begin
          r_ent_vld[i_alloc_tag] <= 1'b1;
          r_ent_we[i_alloc_tag]  <= i_alloc_we_a;
          r_ent_rd[i_alloc_tag]  <= i_alloc_rd_a;
          r_ent_vld[w_tag_b]     <= 1'b1;
          r_ent_we[w_tag_b]      <= i_alloc_we_b;
          r_ent_rd[w_tag_b]      <= i_alloc_rd_b;
          if (i_alloc_we_a) begin
            r_busy[i_alloc_rd_a] <= 1'b1;
            r_tag[i_alloc_rd_a]  <= i_alloc_tag;
          end
          if (i_alloc_we_b) begin
            r_busy[i_alloc_rd_b] <= 1'b1;
            r_tag[i_alloc_rd_b]  <= w_tag_b;
          end
        end
      end
    end
  end

`ifdef COMMIT_BYPASS_EN
  logic w_byp;
  assign w_byp = w_commit & w_e_vld & w_e_we & r_busy[w_e_rd] &
                 (r_tag[w_e_rd] == i_rob_bus_tag);
`endif

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      o_rd_value[p] = r_regs[i_rd_sel[p]];
      o_rd_ready[p] = ~r_busy[i_rd_sel[p]];
      o_rd_tag[p]   = r_busy[i_rd_sel[p]] ? r_tag[i_rd_sel[p]] : '0;
`ifdef COMMIT_BYPASS_EN
      if (w_byp && (i_rd_sel[p] == w_e_rd)) begin
        o_rd_value[p] = i_rob_bus_value;
        o_rd_ready[p] = 1'b1;
        o_rd_tag[p]   = '0;
      end
`endif
    end
  end

  assign o_commit_count = r_commit_count;
  assign o_stale_commit = r_stale;

endmodule
